br_dump: RTL and testbench

Register-file dump engine for on-board debug. On a `start` pulse it walks all 32 general registers through a read port of the register bank (`RR` out, `DR` in) and transmits each 32-bit word over a UART serial line: 8N1, LSB-first bits, MSB-first bytes. It sits beside the datapath on a spare register-bank read port and drives the board's TX pin.

---
 rtl/br_dump_pkg.sv | 15 +
 rtl/br_dump_if.sv | 31 +++
 rtl/uart_tx_byte.sv | 70 +++++++
 rtl/br_dump.sv | 106 ++++++++++
 tb/tb_br_dump.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_dump_pkg.sv
// Shared constants and FSM encoding for the register-file dump engine.
package br_dump_pkg;

  localparam int unsigned NUM_REGS      = 32;
  localparam int unsigned BYTES_PER_REG = 4;
  localparam int unsigned FRAME_BITS    = 10;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StNext = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

endpackage

// File: rtl/br_dump_if.sv
// Bus between the dump engine and its surroundings: request, bank read port, TX pin, status.
interface br_dump_if;

  logic        start;
  logic [4:0]  RR;
  logic [31:0] DR;
  logic        tx;
  logic        busy;
  logic        done;

  // Environment side: issues requests and serves the bank read port
  modport master (
    output start,
    output DR,
    input  RR,
    input  tx,
    input  busy,
    input  done
  );

  // Dump engine side
  modport slave (
    input  start,
    input  DR,
    output RR,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer. The frame is held in a shift register whose LSB is the line.
module uart_tx_byte
  import br_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  active_q, active_d;
  logic                  bit_end;

  assign bit_end = active_q && (cnt_q == CntW'(CLKS_PER_BIT - 1));
  // Fires in the last cycle of the stop bit
  assign tx_done = bit_end && (bit_q == 4'(FRAME_BITS - 1));
  assign tx      = frame_q[0];

  // Next-state: load a frame on start, then shift one bit per bit period
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    active_d = active_q;
    if (!active_q) begin
      if (tx_start) begin
        active_d = 1'b1;
        frame_d  = {1'b1, tx_byte, 1'b0};
        cnt_d    = '0;
        bit_d    = '0;
      end
    end else if (bit_end) begin
      cnt_d   = '0;
      // Shifting in ones leaves the line idle-high once the stop bit leaves
      frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
      if (tx_done) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '1;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/br_dump.sv
// Register-file dump engine: reads all general registers and sends each word MSB-byte first.
module br_dump
  import br_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input logic      clk,
  input logic      rst,
  br_dump_if.slave bus
);

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shadow_q, shadow_d;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        ser_done;
  logic        tx_w;

  // The index register doubles as the read address, so RR holds outside READ
  assign bus.RR   = idx_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.tx   = tx_w;

  // Byte b of the shadow word is bits [31-8b -: 8]
  assign tx_byte = 8'(shadow_q >> (5'd24 - {byte_q, 3'b000}));

  // Sequencer: READ -> (SEND -> WAIT) x4 -> NEXT per register, DONE after the last
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    tx_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        shadow_d = bus.DR;
        byte_d   = '0;
        state_d  = StSend;
      end
      StSend: begin
        tx_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (ser_done) begin
          if (byte_q != 2'(BYTES_PER_REG - 1)) begin
            byte_d  = byte_q + 2'd1;
            state_d = StSend;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (idx_q == 5'(NUM_REGS - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_byte (tx_byte),
    .tx      (tx_w),
    .tx_done (ser_done)
  );

endmodule

// File: tb/tb_br_dump.sv
// Directed bench for br_dump with CLKS_PER_BIT=4, a behavioural register bank and a UART decoder.
module tb_br_dump;

  localparam int unsigned CPB = 4;
  // READ + 4 x (SEND + 40) + NEXT
  localparam int REG_CYC = 166;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_dump_if bus ();

  logic [31:0] bank [32];
  assign bus.DR = bank[bus.RR];

  br_dump #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: centre-samples each bit on the falling edge
  logic [7:0] rxq [$];
  int         ferr     = 0;
  int         done_cnt = 0;
  bit         rx_active = 1'b0;
  int         rx_cnt   = 0;
  logic [7:0] rx_sh    = '0;
  logic [2:0] rx_bi;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (bus.tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
        rx_bi        = 3'((rx_cnt - 6) / 4);
        rx_sh[rx_bi] = bus.tx;
      end
      if (rx_cnt == 38) begin
        if (bus.tx !== 1'b1) ferr++;
        rxq.push_back(rx_sh);
        rx_active = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    rxq.delete();
    ferr     = 0;
    done_cnt = 0;
  endtask

  // Start is held across one rising edge; c0 is the cycle count seen in the READ cycle
  task automatic pulse_start(output int c0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && rxq.size() < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.tx, bus.busy, bus.done, bus.RR} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d tx=%b busy=%b done=%b RR=%0d required tx=1 busy=0 done=0 RR=0",
                 i, bus.tx, bus.busy, bus.done, bus.RR);
      end
    end
  endtask

  task automatic test_frame(output int c0);
    logic [7:0] exp8 [8];
    logic       exp_tx;
    exp8 = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    clear_mon();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_before_start got=%b required=0", bus.busy);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got=%b required=1", bus.busy);
    end
    // READ and SEND idle-high, start bit low for 4 cycles, then data bit 0 of A5 = 1
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      exp_tx = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
      checks++;
      if (bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL start_bit_timing cycle=%0d tx=%b required=%b", k + 1, bus.tx, exp_tx);
      end
    end
    wait_bytes(8, 8 * 41 + 40);
    checks++;
    if (rxq.size() < 8) begin
      failures++;
      $display("FAIL first_bytes_count got=%0d required>=8", rxq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rxq[i] !== exp8[i]) begin
          failures++;
          $display("FAIL frame_byte%0d got=%h required=%h", i, rxq[i], exp8[i]);
        end
      end
    end
  endtask

  task automatic test_full_dump(input int c0);
    bit         ok;
    logic [7:0] exp4 [4];
    exp4 = '{8'hA5, 8'hA5, 8'h00, 8'h1F};
    wait_done(6000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout got=none required=pulse");
    end
    // DONE is the 5313th cycle counting READ of reg 0 as the first
    checks++;
    if (cyc - c0 != 5312) begin
      failures++;
      $display("FAIL done_latency got=%0d required=%0d", cyc - c0 + 1, 5313);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_done got=%b required=0", bus.busy);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL done_count got=%0d required=1", done_cnt);
    end
    checks++;
    if (rxq.size() != 128 || ferr != 0) begin
      failures++;
      $display("FAIL frame_count got=%0d ferr=%0d required=128 ferr=0", rxq.size(), ferr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rxq[124 + i] !== exp4[i]) begin
          failures++;
          $display("FAIL reg31_byte%0d got=%h required=%h", i, rxq[124 + i], exp4[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int c0;
    int d;
    bit ok;
    clear_mon();
    pulse_start(c0);
    wait_cyc(c0 + 500);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(c0 + 3000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(c0 + 5000);
    bus.start = 1'b1;
    wait_done(1000, ok);
    d = cyc;
    checks++;
    if (!ok || d - c0 != 5312) begin
      failures++;
      $display("FAIL busy_done_latency ok=%0d got=%0d required=5313", ok, d - c0 + 1);
    end
    @(negedge clk);
    checks++;
    if (done_cnt != 1 || rxq.size() != 128) begin
      failures++;
      $display("FAIL ignore_start got done=%0d frames=%0d required done=1 frames=128",
               done_cnt, rxq.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_gap_busy got=%b required=0", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.RR !== 5'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_read got RR=%0d busy=%b required RR=0 busy=1", bus.RR, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL restart_send_idle got=%b required=1", bus.tx);
    end
    @(negedge clk);
    checks++;
    if (bus.tx !== 1'b0) begin
      failures++;
      $display("FAIL restart_start_bit got=%b required=0", bus.tx);
    end
    bus.start = 1'b0;
    do_reset(2);
  endtask

  task automatic test_reset_mid();
    int         c0;
    bit         bad;
    logic [7:0] exp4 [4];
    exp4 = '{8'hA5, 8'hA5, 8'h00, 8'h00};
    clear_mon();
    pulse_start(c0);
    // Reg 10, byte 1, data bit 3 spans cycles +59..+62 of that register
    wait_cyc(c0 + 10 * REG_CYC + 60);
    checks++;
    if (bus.tx !== 1'b0 || rxq.size() != 41) begin
      failures++;
      $display("FAIL pre_reset_position got tx=%b bytes=%0d required tx=0 bytes=41",
               bus.tx, rxq.size());
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.tx, bus.busy, bus.done, bus.RR} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL mid_reset got tx=%b busy=%b done=%b RR=%0d required tx=1 busy=0 done=0 RR=0",
               bus.tx, bus.busy, bus.done, bus.RR);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || done_cnt != 0 || rxq.size() != 41) begin
      failures++;
      $display("FAIL after_reset got tx_low=%0d done=%0d bytes=%0d required 0 0 41",
               bad, done_cnt, rxq.size());
    end
    clear_mon();
    pulse_start(c0);
    wait_bytes(4, 4 * 41 + 40);
    checks++;
    if (rxq.size() < 4) begin
      failures++;
      $display("FAIL redump_count got=%0d required>=4", rxq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rxq[i] !== exp4[i]) begin
          failures++;
          $display("FAIL redump_byte%0d got=%h required=%h", i, rxq[i], exp4[i]);
        end
      end
    end
    do_reset(2);
  endtask

  task automatic test_write_during_dump();
    int         c0;
    bit         ok;
    logic [7:0] e20 [4];
    logic [7:0] e3 [4];
    e20 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    e3  = '{8'hA5, 8'hA5, 8'h00, 8'h03};
    clear_mon();
    pulse_start(c0);
    wait_cyc(c0 + 5 * REG_CYC + 20);
    bank[20] = 32'hDEADBEEF;
    bank[3]  = 32'h33333333;
    wait_done(6000, ok);
    @(negedge clk);
    checks++;
    if (!ok || rxq.size() != 128) begin
      failures++;
      $display("FAIL write_dump_count got done=%0d frames=%0d required done=1 frames=128",
               ok, rxq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rxq[80 + i] !== e20[i]) begin
          failures++;
          $display("FAIL reg20_byte%0d got=%h required=%h", i, rxq[80 + i], e20[i]);
        end
        checks++;
        if (rxq[12 + i] !== e3[i]) begin
          failures++;
          $display("FAIL reg3_byte%0d got=%h required=%h", i, rxq[12 + i], e3[i]);
        end
      end
    end
    bank[20] = 32'hA5A50014;
    bank[3]  = 32'hA5A50003;
  endtask

  initial begin
    int c0;
    bus.start = 1'b0;
    for (int k = 0; k < 32; k++) bank[k] = 32'hA5A50000 | 32'(k);
    bank[1] = 32'h12345678;
    test_reset();
    test_frame(c0);
    test_full_dump(c0);
    test_start_while_busy();
    test_reset_mid();
    test_write_during_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
